// File: rtl/control_sequencer.sv
// Control unit: instruction register, T-state step counter and microcode decode.
// Fetches opcode+operand from the shared bus, sequences execute micro-steps, and
// freezes on HLT until reset.
module control_sequencer #(
   parameter int unsigned T_STATES = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  bus_in,
   input  logic        flag_c,
   input  logic        flag_z,
   output logic [3:0]  ir_addr,
   output logic [15:0] ctrl,
   output logic [2:0]  step,
   output logic        halted
);

   // Control word bit positions
   localparam int unsigned BitHlt = 15;
   localparam int unsigned BitMi  = 14;
   localparam int unsigned BitRi  = 13;
   localparam int unsigned BitRo  = 12;
   localparam int unsigned BitIo  = 11;
   localparam int unsigned BitIi  = 10;
   localparam int unsigned BitAi  = 9;
   localparam int unsigned BitAo  = 8;
   localparam int unsigned BitEo  = 7;
   localparam int unsigned BitSu  = 6;
   localparam int unsigned BitBi  = 5;
   localparam int unsigned BitOi  = 4;
   localparam int unsigned BitCe  = 3;
   localparam int unsigned BitCo  = 2;
   localparam int unsigned BitJ   = 1;
   localparam int unsigned BitFi  = 0;

   localparam logic [3:0] LastStep = 4'(T_STATES - 1);

   // Microcode ROM; steps are 4 bits wide so step+1 never wraps for T_STATES=8
   function automatic logic [15:0] word_at(input logic [3:0] s, input logic [3:0] op,
                                           input logic c, input logic z);
      logic [15:0] w;
      w = '0;
      if (s == 4'd0) begin
         w[BitCo] = 1'b1; w[BitMi] = 1'b1;
      end else if (s == 4'd1) begin
         w[BitRo] = 1'b1; w[BitIi] = 1'b1; w[BitCe] = 1'b1;
      end else begin
         case (op)
            4'h1: begin  // LDA
               if (s == 4'd2) begin w[BitIo] = 1'b1; w[BitMi] = 1'b1; end
               if (s == 4'd3) begin w[BitRo] = 1'b1; w[BitAi] = 1'b1; end
            end
            4'h2, 4'h3: begin  // ADD, SUB
               if (s == 4'd2) begin w[BitIo] = 1'b1; w[BitMi] = 1'b1; end
               if (s == 4'd3) begin w[BitRo] = 1'b1; w[BitBi] = 1'b1; end
               if (s == 4'd4) begin
                  w[BitEo] = 1'b1; w[BitAi] = 1'b1; w[BitFi] = 1'b1;
                  w[BitSu] = (op == 4'h3);
               end
            end
            4'h4: begin  // STA
               if (s == 4'd2) begin w[BitIo] = 1'b1; w[BitMi] = 1'b1; end
               if (s == 4'd3) begin w[BitAo] = 1'b1; w[BitRi] = 1'b1; end
            end
            4'h5: if (s == 4'd2) begin w[BitIo] = 1'b1; w[BitAi] = 1'b1; end
            4'h6: if (s == 4'd2) begin w[BitIo] = 1'b1; w[BitJ] = 1'b1; end
            4'h7: if (s == 4'd2 && c) begin w[BitIo] = 1'b1; w[BitJ] = 1'b1; end
            4'h8: if (s == 4'd2 && z) begin w[BitIo] = 1'b1; w[BitJ] = 1'b1; end
            4'hE: if (s == 4'd2) begin w[BitAo] = 1'b1; w[BitOi] = 1'b1; end
            4'hF: if (s == 4'd2) w[BitHlt] = 1'b1;
            default: w = '0;
         endcase
      end
      return w;
   endfunction

   logic [2:0]  step_q, step_d;
   logic [7:0]  ir_q, ir_d;
   logic        halted_q, halted_d;
   logic [15:0] word_cur;
   logic [15:0] word_nxt;

   // Decode current and look-ahead microcode words, gate output by reset/halt
   always_comb begin
      word_cur = word_at({1'b0, step_q}, ir_q[7:4], flag_c, flag_z);
      word_nxt = word_at({1'b0, step_q} + 4'd1, ir_q[7:4], flag_c, flag_z);
      if (rst) begin
         ctrl = '0;
      end else if (halted_q) begin
         ctrl = 16'h8000;
      end else begin
         ctrl = word_cur;
      end
   end

   // Next-state: IR load, step advance with early termination, halt latch
   always_comb begin
      step_d   = step_q;
      ir_d     = ir_q;
      halted_d = halted_q;
      if (!halted_q) begin
         if (word_cur[BitHlt]) begin
            halted_d = 1'b1;  // step and IR freeze on the HLT edge
         end else begin
            if (word_cur[BitIi]) ir_d = bus_in;
            if (step_q < 3'd2) begin
               step_d = step_q + 3'd1;
            end else if (({1'b0, step_q} == LastStep) || (word_nxt == '0)) begin
               step_d = '0;
            end else begin
               step_d = step_q + 3'd1;
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q   <= '0;
         ir_q     <= '0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         ir_q     <= ir_d;
         halted_q <= halted_d;
      end
   end

   assign ir_addr = ir_q[3:0];
   assign step    = step_q;
   assign halted  = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, hand-written halt and
// truncation sequences, then randomized traffic against an instruction-level model.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  bus_in;
   logic        flag_c, flag_z;
   logic [15:0] ctrl5, ctrl4;
   logic [2:0]  step5, step4;
   logic [3:0]  addr5, addr4;
   logic        halted5, halted4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   control_sequencer #(.T_STATES(5)) dut5 (
      .clk(clk), .rst(rst), .bus_in(bus_in), .flag_c(flag_c), .flag_z(flag_z),
      .ir_addr(addr5), .ctrl(ctrl5), .step(step5), .halted(halted5)
   );

   control_sequencer #(.T_STATES(4)) dut4 (
      .clk(clk), .rst(rst), .bus_in(bus_in), .flag_c(flag_c), .flag_z(flag_z),
      .ir_addr(addr4), .ctrl(ctrl4), .step(step4), .halted(halted4)
   );

   typedef struct packed {
      logic        r;
      logic [7:0]  bus;
      logic        fc;
      logic        fz;
      logic [15:0] ctrl;
      logic [2:0]  step;
      logic [3:0]  addr;
      logic        h;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive just after posedge, leave time for outputs to settle
   task automatic cyc(input logic r, input logic [7:0] b, input logic c, input logic z);
      @(posedge clk);
      #1;
      rst = r; bus_in = b; flag_c = c; flag_z = z;
      #3;
   endtask

   task automatic add(input logic r, input logic [7:0] b, input logic c, input logic z,
                      input logic [15:0] e_ctrl, input logic [2:0] e_step,
                      input logic [3:0] e_addr, input logic e_h);
      tbl.push_back('{r: r, bus: b, fc: c, fz: z, ctrl: e_ctrl, step: e_step,
                      addr: e_addr, h: e_h});
   endtask

   // Execute word k (k=0 is T2) of an instruction, straight from the opcode table
   function automatic logic [15:0] exec_word(input logic [3:0] op, input int k,
                                             input logic c, input logic z);
      logic [15:0] lst[$];
      case (op)
         4'h1: lst = '{16'h4800, 16'h1200};
         4'h2: lst = '{16'h4800, 16'h1020, 16'h0281};
         4'h3: lst = '{16'h4800, 16'h1020, 16'h02C1};
         4'h4: lst = '{16'h4800, 16'h2100};
         4'h5: lst = '{16'h0A00};
         4'h6: lst = '{16'h0802};
         4'h7: lst = c ? '{16'h0802} : '{16'h0000};
         4'h8: lst = z ? '{16'h0802} : '{16'h0000};
         4'hE: lst = '{16'h0110};
         4'hF: lst = '{16'h8000};
         default: lst = '{16'h0000};
      endcase
      return (k < lst.size()) ? lst[k] : 16'h0000;
   endfunction

   // Total cycles of an instruction: fetch (2) plus at least one execute step,
   // up to the run of non-zero words, capped by the step budget
   function automatic int instr_len(input logic [3:0] op, input logic c, input logic z,
                                    input int t);
      int n = 0;
      while (n < t - 2 && exec_word(op, n, c, z) != 16'h0000) n++;
      return 2 + ((n == 0) ? 1 : n);
   endfunction

   function automatic logic [15:0] model_word(input int idx, input logic [3:0] op,
                                              input logic c, input logic z);
      if (idx == 0) return 16'h4004;
      if (idx == 1) return 16'h1408;
      return exec_word(op, idx - 2, c, z);
   endfunction

   int          m_idx[2];
   logic [7:0]  m_ir[2];
   logic        m_h[2];
   int          m_t[2] = '{5, 4};

   initial begin
      logic [15:0] e_ctrl;
      logic [15:0] a_ctrl;
      logic [2:0]  a_step;
      logic [3:0]  a_addr;
      logic        a_h;
      logic        r;
      logic [7:0]  b;
      logic        c, z;
      int          hcnt;

      rst = 1'b1; bus_in = '0; flag_c = 1'b0; flag_z = 1'b0;

      // rst, bus, fc, fz, ctrl, step, addr, halted
      add(1, 8'h00, 0, 0, 16'h0000, 0, 4'h0, 0);
      add(0, 8'h00, 0, 0, 16'h4004, 0, 4'h0, 0);  // first cycle after release is T0
      add(0, 8'h1E, 0, 0, 16'h1408, 1, 4'h0, 0);  // LDA 0xE
      add(0, 8'h00, 0, 0, 16'h4800, 2, 4'hE, 0);
      add(0, 8'h00, 0, 0, 16'h1200, 3, 4'hE, 0);
      add(0, 8'h00, 0, 0, 16'h4004, 0, 4'hE, 0);
      add(0, 8'h2F, 0, 0, 16'h1408, 1, 4'hE, 0);  // ADD
      add(0, 8'h00, 0, 0, 16'h4800, 2, 4'hF, 0);
      add(0, 8'h00, 0, 0, 16'h1020, 3, 4'hF, 0);
      add(0, 8'h00, 0, 0, 16'h0281, 4, 4'hF, 0);
      add(0, 8'h00, 0, 0, 16'h4004, 0, 4'hF, 0);
      add(0, 8'h3A, 0, 0, 16'h1408, 1, 4'hF, 0);  // SUB
      add(0, 8'h00, 0, 0, 16'h4800, 2, 4'hA, 0);
      add(0, 8'h00, 0, 0, 16'h1020, 3, 4'hA, 0);
      add(0, 8'h00, 0, 0, 16'h02C1, 4, 4'hA, 0);
      add(0, 8'h00, 0, 0, 16'h4004, 0, 4'hA, 0);
      add(0, 8'h75, 0, 1, 16'h1408, 1, 4'hA, 0);  // JC taken
      add(0, 8'h00, 1, 0, 16'h0802, 2, 4'h5, 0);
      add(0, 8'h00, 0, 0, 16'h4004, 0, 4'h5, 0);
      add(0, 8'h75, 0, 0, 16'h1408, 1, 4'h5, 0);  // JC not taken
      add(0, 8'h00, 0, 1, 16'h0000, 2, 4'h5, 0);
      add(0, 8'h00, 0, 0, 16'h4004, 0, 4'h5, 0);
      add(0, 8'h83, 0, 0, 16'h1408, 1, 4'h5, 0);  // JZ taken
      add(0, 8'h00, 0, 1, 16'h0802, 2, 4'h3, 0);
      add(0, 8'h00, 0, 0, 16'h4004, 0, 4'h3, 0);
      add(0, 8'h83, 0, 0, 16'h1408, 1, 4'h3, 0);  // JZ not taken
      add(0, 8'h00, 1, 0, 16'h0000, 2, 4'h3, 0);
      add(0, 8'h00, 0, 0, 16'h4004, 0, 4'h3, 0);
      add(0, 8'h27, 0, 0, 16'h1408, 1, 4'h3, 0);  // ADD, reset mid-T3
      add(0, 8'h00, 0, 0, 16'h4800, 2, 4'h7, 0);
      add(1, 8'h00, 0, 0, 16'h0000, 0, 4'h0, 0);
      add(0, 8'h00, 0, 0, 16'h4004, 0, 4'h0, 0);
      add(0, 8'hF0, 0, 0, 16'h1408, 1, 4'h0, 0);  // HLT
      add(0, 8'h00, 0, 0, 16'h8000, 2, 4'h0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].r, tbl[i].bus, tbl[i].fc, tbl[i].fz);
         chk($sformatf("vec%0d ctrl", i), ctrl5, tbl[i].ctrl);
         chk($sformatf("vec%0d step", i), {13'd0, step5}, {13'd0, tbl[i].step});
         chk($sformatf("vec%0d ir_addr", i), {12'd0, addr5}, {12'd0, tbl[i].addr});
         chk($sformatf("vec%0d halted", i), {15'd0, halted5}, {15'd0, tbl[i].h});
      end

      // Frozen while halted, regardless of bus activity
      for (int i = 0; i < 20; i++) begin
         cyc(0, (i % 2 == 0) ? 8'h55 : 8'hAA, 0, 0);
         chk("halt ctrl", ctrl5, 16'h8000);
         chk("halt step", {13'd0, step5}, 16'd2);
         chk("halt flag", {15'd0, halted5}, 16'd1);
         chk("halt ir_addr", {12'd0, addr5}, 16'd0);
      end
      cyc(1, 8'h00, 0, 0);
      chk("halt rst ctrl", ctrl5, 16'h0000);
      chk("halt rst flag", {15'd0, halted5}, 16'd0);
      cyc(0, 8'h00, 0, 0);
      chk("post halt T0", ctrl5, 16'h4004);

      // Four-step variant: ADD truncated after T3
      cyc(1, 8'h00, 0, 0);
      cyc(0, 8'h00, 0, 0);
      chk("t4 T0", ctrl4, 16'h4004);
      cyc(0, 8'h2C, 0, 0);
      chk("t4 T1", ctrl4, 16'h1408);
      cyc(0, 8'h00, 0, 0);
      chk("t4 T2", ctrl4, 16'h4800);
      cyc(0, 8'h00, 0, 0);
      chk("t4 T3", ctrl4, 16'h1020);
      chk("t4 T3 step", {13'd0, step4}, 16'd3);
      cyc(0, 8'h00, 0, 0);
      chk("t4 wrap", ctrl4, 16'h4004);
      chk("t4 wrap step", {13'd0, step4}, 16'd0);

      // Randomized traffic against the instruction-level model
      cyc(1, 8'h00, 0, 0);
      for (int k = 0; k < 2; k++) begin
         m_idx[k] = 0; m_ir[k] = 8'h00; m_h[k] = 1'b0;
      end
      hcnt = 0;
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 59) == 0) || (hcnt > 6);
         b = 8'($urandom);
         c = 1'($urandom);
         z = 1'($urandom);
         cyc(r, b, c, z);
         hcnt = (m_h[0] || m_h[1]) && !r ? hcnt + 1 : 0;
         for (int k = 0; k < 2; k++) begin
            if (r) begin
               m_idx[k] = 0; m_ir[k] = 8'h00; m_h[k] = 1'b0;
            end
            if (r) e_ctrl = 16'h0000;
            else if (m_h[k]) e_ctrl = 16'h8000;
            else e_ctrl = model_word(m_idx[k], m_ir[k][7:4], c, z);
            a_ctrl = (k == 0) ? ctrl5 : ctrl4;
            a_step = (k == 0) ? step5 : step4;
            a_addr = (k == 0) ? addr5 : addr4;
            a_h    = (k == 0) ? halted5 : halted4;
            chk($sformatf("rand T%0d ctrl", m_t[k]), a_ctrl, e_ctrl);
            chk($sformatf("rand T%0d step", m_t[k]), {13'd0, a_step}, 16'(m_idx[k]));
            chk($sformatf("rand T%0d ir_addr", m_t[k]), {12'd0, a_addr},
                {12'd0, m_ir[k][3:0]});
            chk($sformatf("rand T%0d halted", m_t[k]), {15'd0, a_h}, {15'd0, m_h[k]});
            if (!r && !m_h[k]) begin
               if (e_ctrl[15]) begin
                  m_h[k] = 1'b1;
               end else begin
                  if (m_idx[k] + 1 >= instr_len(m_ir[k][7:4], c, z, m_t[k])) m_idx[k] = 0;
                  else m_idx[k] = m_idx[k] + 1;
                  if (e_ctrl[10]) m_ir[k] = b;
               end
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
